// File: rtl/wb_user_bus_arbiter.sv
// Wishbone user-area controller: decodes the BASE_NIB window, routes one transfer at a time to
// the UART (adr[27]=0) or accelerator (adr[27]=1), and force-completes transfers a slave never acks.
//
// Handshake: a master request is taken only when cyc & stb hit the window in IDLE. The target slave
// sees cyc=stb=1 for every BUSY cycle and completes by pulsing its ack while that strobe is high.
// The master receives exactly one wbs_ack_o pulse per accepted transfer, unless it drops cyc first.
module wb_user_bus_arbiter #(
  parameter int unsigned TIMEOUT  = 64,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF,
  parameter logic [3:0]  BASE_NIB = 4'h3
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic        s0_cyc_o,
  output logic        s0_stb_o,
  input  logic        s0_ack_i,
  input  logic [31:0] s0_dat_i,
  output logic        s1_cyc_o,
  output logic        s1_stb_o,
  input  logic        s1_ack_i,
  input  logic [31:0] s1_dat_i,
  output logic        timeout_o,
  output logic [7:0]  timeout_cnt_o,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] wdat_q, wdat_d;
  logic        tgt_q, tgt_d;
  logic [7:0]  wdog_q, wdog_d;
  logic [31:0] rdata_q, rdata_d;
  logic        timeout_q, timeout_d;
  logic [7:0]  tcnt_q, tcnt_d;

  logic        hit;
  logic        tgt_ack;
  logic [31:0] tgt_dat;
  logic        busy;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      we_q      <= 1'b0;
      sel_q     <= 4'h0;
      adr_q     <= 32'h0;
      wdat_q    <= 32'h0;
      tgt_q     <= 1'b0;
      wdog_q    <= 8'h0;
      rdata_q   <= 32'h0;
      timeout_q <= 1'b0;
      tcnt_q    <= 8'h0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      adr_q     <= adr_d;
      wdat_q    <= wdat_d;
      tgt_q     <= tgt_d;
      wdog_q    <= wdog_d;
      rdata_q   <= rdata_d;
      timeout_q <= timeout_d;
      tcnt_q    <= tcnt_d;
    end
  end

  // Acks from the slave that is not the latched target never reach the FSM.
  always_comb begin
    hit     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:28] == BASE_NIB);
    tgt_ack = tgt_q ? s1_ack_i : s0_ack_i;
    tgt_dat = tgt_q ? s1_dat_i : s0_dat_i;

    state_d   = state_q;
    we_d      = we_q;
    sel_d     = sel_q;
    adr_d     = adr_q;
    wdat_d    = wdat_q;
    tgt_d     = tgt_q;
    wdog_d    = wdog_q;
    rdata_d   = rdata_q;
    timeout_d = 1'b0;
    tcnt_d    = tcnt_q;

    case (state_q)
      ST_IDLE: begin
        if (hit) begin
          we_d    = wbs_we_i;
          sel_d   = wbs_sel_i;
          adr_d   = wbs_adr_i;
          wdat_d  = wbs_dat_i;
          tgt_d   = wbs_adr_i[27];
          wdog_d  = 8'h0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!wbs_cyc_i) begin
          state_d = ST_IDLE;
        end else if (tgt_ack) begin
          rdata_d = tgt_dat;
          state_d = ST_RESP;
        end else if (wdog_q == WDOG_LAST) begin
          rdata_d   = ERR_DATA;
          timeout_d = 1'b1;
          if (tcnt_q != 8'hFF) tcnt_d = tcnt_q + 8'h1;
          state_d   = ST_RESP;
        end else begin
          wdog_d = wdog_q + 8'h1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy          = (state_q == ST_BUSY);
    s0_cyc_o      = busy & ~tgt_q;
    s0_stb_o      = busy & ~tgt_q;
    s1_cyc_o      = busy & tgt_q;
    s1_stb_o      = busy & tgt_q;
    wbs_ack_o     = (state_q == ST_RESP);
    wbs_dat_o     = wbs_ack_o ? rdata_q : 32'h0;
    s_we_o        = we_q;
    s_sel_o       = sel_q;
    s_adr_o       = adr_q;
    s_dat_o       = wdat_q;
    timeout_o     = timeout_q;
    timeout_cnt_o = tcnt_q;
    state_o       = state_q;
  end

endmodule

// File: tb/tb_wb_user_bus_arbiter.sv
// Directed bench for wb_user_bus_arbiter: the master driver pushes expected read data into exp_q
// and a negedge monitor pops one entry per wbs_ack_o pulse.
module tb_wb_user_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic        s0_cyc_o, s0_stb_o, s0_ack_i;
  logic [31:0] s0_dat_i;
  logic        s1_cyc_o, s1_stb_o, s1_ack_i;
  logic [31:0] s1_dat_i;
  logic        timeout_o;
  logic [7:0]  timeout_cnt_o;
  logic [1:0]  state_o;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  wb_user_bus_arbiter #(.TIMEOUT(16), .ERR_DATA(32'hDEAD_BEEF), .BASE_NIB(4'h3)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .s_we_o(s_we_o), .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s0_cyc_o(s0_cyc_o), .s0_stb_o(s0_stb_o), .s0_ack_i(s0_ack_i), .s0_dat_i(s0_dat_i),
    .s1_cyc_o(s1_cyc_o), .s1_stb_o(s1_stb_o), .s1_ack_i(s1_ack_i), .s1_dat_i(s1_dat_i),
    .timeout_o(timeout_o), .timeout_cnt_o(timeout_cnt_o), .state_o(state_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (wbs_ack_o) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL ack_unexpected: got ack with dat %h expected no ack", wbs_dat_o);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (wbs_dat_o !== e) begin
            n_fail++;
            $display("FAIL ack_data: got %h expected %h", wbs_dat_o, e);
          end
        end
      end else begin
        check("dat_zero_no_ack", wbs_dat_o, 32'h0);
      end
    end
  end

  task automatic clear_slaves();
    s0_ack_i = 1'b0; s1_ack_i = 1'b0; s0_dat_i = 32'h0; s1_dat_i = 32'h0;
  endtask

  // Master driver plus target-slave responder. lat = cycles after first stb before the slave
  // acks (-1: never); abort_at = BUSY cycle index at which cyc drops (-1: never).
  task automatic xfer(input logic x_we, input logic [31:0] x_adr, input logic [31:0] x_dat,
                      input logic [3:0] x_sel, input int lat, input logic [31:0] sdat,
                      input int abort_at, output int ack_k, output int to_k);
    logic tgt;
    bit found;
    tgt = x_adr[27];
    ack_k = -1;
    to_k = -1;
    found = 1'b0;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = x_we; adr = x_adr; wdat = x_dat; sel = x_sel;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (s0_stb_o || s1_stb_o) begin
        found = 1'b1;
        break;
      end
    end
    check("stb_seen", 32'(found), 32'h1);
    if (found) begin
      check("tgt_stb",   32'(tgt ? (s1_stb_o & s1_cyc_o) : (s0_stb_o & s0_cyc_o)), 32'h1);
      check("other_stb", 32'(tgt ? (s0_stb_o | s0_cyc_o) : (s1_stb_o | s1_cyc_o)), 32'h0);
      check("s_we",  32'(s_we_o), 32'(x_we));
      check("s_adr", s_adr_o, x_adr);
      check("s_dat", s_dat_o, x_dat);
      check("s_sel", 32'(s_sel_o), 32'(x_sel));
      for (int k = 0; k <= 40; k++) begin
        clear_slaves();
        if (timeout_o) to_k = k;
        if (wbs_ack_o) begin
          ack_k = k;
          break;
        end
        if (abort_at >= 0 && k == abort_at + 1)
          check("abort_stb_drop", 32'(s0_stb_o | s1_stb_o | s0_cyc_o | s1_cyc_o), 32'h0);
        if (abort_at >= 0 && k == abort_at + 4) break;
        if (k == 0) begin
          // Junk ack from the non-target slave must be ignored.
          if (tgt) begin s0_ack_i = 1'b1; s0_dat_i = 32'hBAD0_BAD0; end
          else     begin s1_ack_i = 1'b1; s1_dat_i = 32'hBAD0_BAD0; end
        end
        if (k == lat) begin
          if (tgt) begin s1_ack_i = 1'b1; s1_dat_i = sdat; end
          else     begin s0_ack_i = 1'b1; s0_dat_i = sdat; end
        end
        if (k == abort_at) begin cyc = 1'b0; stb = 1'b0; end
        @(negedge clk);
      end
    end
    clear_slaves();
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  initial begin
    int ak, tk;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'h0; wdat = 32'h0;
    clear_slaves();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ack", 32'(wbs_ack_o), 32'h0);
    check("rst_strobes", 32'({s0_cyc_o, s0_stb_o, s1_cyc_o, s1_stb_o}), 32'h0);
    check("rst_s_bus", s_adr_o | s_dat_o | 32'(s_sel_o) | 32'(s_we_o), 32'h0);
    check("rst_timeout", 32'({timeout_o, timeout_cnt_o}), 32'h0);
    check("rst_state", 32'(state_o), 32'h0);

    // Read from accelerator, ack 2 cycles after stb
    exp_q.push_back(32'h0000_1234);
    xfer(1'b0, 32'h3800_0010, 32'h0, 4'hF, 2, 32'h0000_1234, -1, ak, tk);
    check("rd_ack_lat", 32'(ak), 32'd3);
    check("rd_no_timeout", 32'(tk), 32'hFFFF_FFFF);

    // Zero-wait write to UART
    exp_q.push_back(32'h0000_0077);
    xfer(1'b1, 32'h3000_0004, 32'h0000_00A5, 4'h1, 0, 32'h0000_0077, -1, ak, tk);
    check("wr_ack_lat", 32'(ak), 32'd1);

    // Out-of-window request held for 10 cycles
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; adr = 32'h2600_0000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("miss_strobes", 32'(s0_stb_o | s1_stb_o), 32'h0);
      check("miss_state", 32'(state_o), 32'h0);
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;

    // Accelerator never acks: forced completion after 16 BUSY cycles
    exp_q.push_back(32'hDEAD_BEEF);
    xfer(1'b0, 32'h3800_0040, 32'h0, 4'hF, -1, 32'h0, -1, ak, tk);
    check("to_pulse_cycle", 32'(tk), 32'd16);
    check("to_ack_cycle", 32'(ak), 32'd16);
    check("to_cnt_1", 32'(timeout_cnt_o), 32'd1);

    // Ack on the last watchdog cycle beats the timeout
    exp_q.push_back(32'h0000_5A5A);
    xfer(1'b0, 32'h3800_0080, 32'h0, 4'hF, 15, 32'h0000_5A5A, -1, ak, tk);
    check("edge_ack_cycle", 32'(ak), 32'd16);
    check("edge_no_timeout", 32'(tk), 32'hFFFF_FFFF);
    check("edge_cnt_same", 32'(timeout_cnt_o), 32'd1);

    // Master drops cyc in BUSY
    xfer(1'b0, 32'h3000_0008, 32'h0, 4'hF, -1, 32'h0, 3, ak, tk);
    check("abort_no_ack", 32'(ak), 32'hFFFF_FFFF);
    check("abort_state", 32'(state_o), 32'h0);

    // Reset while BUSY, then a late slave ack
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0020; sel = 4'hF;
    @(negedge clk); @(negedge clk);
    check("pre_rst_busy", 32'(s0_stb_o), 32'h1);
    @(posedge clk); #1;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_outputs", 32'({wbs_ack_o, s0_cyc_o, s0_stb_o, s1_cyc_o, s1_stb_o, timeout_o}), 32'h0);
    check("mid_rst_s_bus", s_adr_o | s_dat_o | 32'(s_sel_o) | 32'(s_we_o), 32'h0);
    check("mid_rst_cnt", 32'(timeout_cnt_o), 32'h0);
    s0_ack_i = 1'b1; s0_dat_i = 32'h1111_2222;
    @(negedge clk);
    clear_slaves();
    repeat (3) @(negedge clk);
    check("late_ack_state", 32'(state_o), 32'h0);
    exp_q.push_back(32'hCAFE_0001);
    xfer(1'b0, 32'h3000_0100, 32'h0, 4'hF, 1, 32'hCAFE_0001, -1, ak, tk);
    check("post_rst_ack_lat", 32'(ak), 32'd2);

    // 300 more timeouts: counter saturates at 255
    for (int i = 0; i < 300; i++) begin
      exp_q.push_back(32'hDEAD_BEEF);
      xfer(1'b0, 32'h3800_0000, 32'h0, 4'hF, -1, 32'h0, -1, ak, tk);
      if (i == 253) check("cnt_254", 32'(timeout_cnt_o), 32'd254);
      if (i == 254) check("cnt_255", 32'(timeout_cnt_o), 32'd255);
    end
    check("cnt_saturated", 32'(timeout_cnt_o), 32'd255);

    repeat (5) @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
